// File: rtl/gmem_axi_responder_if.sv
// AXI4 bus bundle between the MMU (initiator) and the GMEM responder.
// master modport: MMU side, drives AW/W/AR and bready/rready.
// slave modport : GMEM side, drives awready/wready/B/arready/R.
// awlock/cache/prot/qos and the AR equivalents are carried but unused by GMEM.
interface gmem_axi_responder_if #(
    parameter int ID_WIDTH    = 4,
    parameter int GMEM_ADDR_W = 28,
    parameter int GMEM_DATA_W = 128
);
    logic [ID_WIDTH-1:0]      awid;
    logic [GMEM_ADDR_W-1:0]   awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awlock;
    logic [3:0]               awcache;
    logic [2:0]               awprot;
    logic [3:0]               awqos;
    logic                     awvalid;
    logic                     awready;

    logic [GMEM_DATA_W-1:0]   wdata;
    logic [GMEM_DATA_W/8-1:0] wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [ID_WIDTH-1:0]      bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [ID_WIDTH-1:0]      arid;
    logic [GMEM_ADDR_W-1:0]   araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arlock;
    logic [3:0]               arcache;
    logic [2:0]               arprot;
    logic [3:0]               arqos;
    logic                     arvalid;
    logic                     arready;

    logic [ID_WIDTH-1:0]      rid;
    logic [GMEM_DATA_W-1:0]   rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/gmem_axi_responder.sv
// GMEM AXI4 responder: single-outstanding write and read bursts on independent
// channel FSMs, backed by a 2**MEM_DEPTH_W x GMEM_DATA_W RAM.
// Ports: clk, clear (synchronous active-high), s_axi (slave modport of
// gmem_axi_responder_if).
// Optional feature macro GMEM_STRB_EN: when defined, wstrb gates each byte
// lane; otherwise every accepted beat writes the whole word.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, accepting awlen+1 beats
// W_RESP  | bvalid high, waiting for bready
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | first RAM read into the output register
// R_DATA  | streaming beats through output register + skid entry
module gmem_axi_responder #(
    parameter int ID_WIDTH    = 4,
    parameter int GMEM_ADDR_W = 28,
    parameter int GMEM_DATA_W = 128,
    parameter int MEM_DEPTH_W = 10
) (
    input logic                  clk,
    input logic                  clear,
    gmem_axi_responder_if.slave  s_axi
);
    localparam int          OFS       = $clog2(GMEM_DATA_W / 8);
    localparam logic [2:0]  FULL_SIZE = 3'(OFS);
    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  SLVERR    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [GMEM_DATA_W-1:0] mem [2**MEM_DEPTH_W];

    w_state_t               w_state;
    logic                   awready_q, wready_q, bvalid_q;
    logic [1:0]             bresp_q;
    logic [ID_WIDTH-1:0]    w_id;
    logic [MEM_DEPTH_W-1:0] w_idx;
    logic [7:0]             w_len, w_cnt;
    logic                   w_bad, w_err, w_fixed;
    logic                   w_fire, w_final;

    r_state_t               r_state;
    logic                   arready_q, rvalid_q, rlast_q;
    logic [1:0]             rresp_q;
    logic [GMEM_DATA_W-1:0] rdata_q;
    logic [ID_WIDTH-1:0]    r_id;
    logic [MEM_DEPTH_W-1:0] r_idx;
    logic [7:0]             r_len;
    logic [8:0]             r_issued;
    logic                   r_bad, r_fixed;
    logic                   sk_valid, sk_last;
    logic [GMEM_DATA_W-1:0] sk_data;
    logic                   r_more, r_beat_last, r_acc;
    logic [GMEM_DATA_W-1:0] r_beat;

    assign w_fire      = (w_state == W_DATA) && wready_q && s_axi.wvalid;
    assign w_final     = (w_cnt == w_len);

    // r_beat is only ever captured into a register, so the RAM read is synchronous;
    // a same-cycle write lands after the read and the read sees the old word.
    assign r_more      = (r_issued <= {1'b0, r_len});
    assign r_beat_last = (r_issued == {1'b0, r_len});
    assign r_beat      = r_bad ? '0 : mem[r_idx];
    assign r_acc       = rvalid_q && s_axi.rready;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = w_id;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rid     = r_id;

    always_ff @(posedge clk) begin
        if (clear) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            w_id      <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_bad     <= 1'b0;
            w_err     <= 1'b0;
            w_fixed   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_axi.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_id      <= s_axi.awid;
                        w_idx     <= s_axi.awaddr[OFS+MEM_DEPTH_W-1:OFS];
                        w_len     <= s_axi.awlen;
                        w_cnt     <= '0;
                        w_bad     <= (s_axi.awsize != FULL_SIZE);
                        w_err     <= 1'b0;
                        w_fixed   <= (s_axi.awburst == 2'b00);
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (s_axi.wlast != w_final) w_err <= 1'b1;
                        if (!w_fixed) w_idx <= w_idx + 1'b1;
                        // wlast never ends the burst early; only the beat count does
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (w_bad || w_err || !s_axi.wlast) ? SLVERR : OKAY;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= OKAY;
                        w_cnt     <= '0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // RAM has no reset so contents survive clear.
    always_ff @(posedge clk) begin
        if (!clear && w_fire && !w_bad) begin
`ifdef GMEM_STRB_EN
            for (int b = 0; b < GMEM_DATA_W / 8; b++) begin
                if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
`else
            mem[w_idx] <= s_axi.wdata;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_issued  <= '0;
            r_bad     <= 1'b0;
            r_fixed   <= 1'b0;
            sk_valid  <= 1'b0;
            sk_last   <= 1'b0;
            sk_data   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        r_id      <= s_axi.arid;
                        r_idx     <= s_axi.araddr[OFS+MEM_DEPTH_W-1:OFS];
                        r_len     <= s_axi.arlen;
                        r_bad     <= (s_axi.arsize != FULL_SIZE);
                        r_fixed   <= (s_axi.arburst == 2'b00);
                        r_issued  <= '0;
                        r_state   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= r_beat;
                    rlast_q  <= r_beat_last;
                    rresp_q  <= r_bad ? SLVERR : OKAY;
                    r_issued <= r_issued + 9'd1;
                    if (!r_fixed) r_idx <= r_idx + 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (r_acc && rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        rresp_q   <= OKAY;
                        rdata_q   <= '0;
                        sk_valid  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end else if (r_acc) begin
                        // skid beat is older than anything still in the RAM
                        if (sk_valid) begin
                            rdata_q <= sk_data;
                            rlast_q <= sk_last;
                            if (r_more) begin
                                sk_data  <= r_beat;
                                sk_last  <= r_beat_last;
                                r_issued <= r_issued + 9'd1;
                                if (!r_fixed) r_idx <= r_idx + 1'b1;
                            end else begin
                                sk_valid <= 1'b0;
                            end
                        end else if (r_more) begin
                            rdata_q  <= r_beat;
                            rlast_q  <= r_beat_last;
                            r_issued <= r_issued + 9'd1;
                            if (!r_fixed) r_idx <= r_idx + 1'b1;
                        end else begin
                            rvalid_q <= 1'b0;
                        end
                    end else if (!rvalid_q) begin
                        if (r_more) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= r_beat;
                            rlast_q  <= r_beat_last;
                            r_issued <= r_issued + 9'd1;
                            if (!r_fixed) r_idx <= r_idx + 1'b1;
                        end
                    end else if (!sk_valid && r_more) begin
                        sk_valid <= 1'b1;
                        sk_data  <= r_beat;
                        sk_last  <= r_beat_last;
                        r_issued <= r_issued + 9'd1;
                        if (!r_fixed) r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic unused_bits;
`ifdef GMEM_STRB_EN
    assign unused_bits = ^{s_axi.awaddr[GMEM_ADDR_W-1:OFS+MEM_DEPTH_W], s_axi.awaddr[OFS-1:0],
                           s_axi.araddr[GMEM_ADDR_W-1:OFS+MEM_DEPTH_W], s_axi.araddr[OFS-1:0],
                           s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                           s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
`else
    assign unused_bits = ^{s_axi.awaddr[GMEM_ADDR_W-1:OFS+MEM_DEPTH_W], s_axi.awaddr[OFS-1:0],
                           s_axi.araddr[GMEM_ADDR_W-1:OFS+MEM_DEPTH_W], s_axi.araddr[OFS-1:0],
                           s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                           s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                           s_axi.wstrb};
`endif
endmodule

// File: doc/gmem_axi_responder.md
# gmem_axi_responder

AXI4 slave model of global memory (GMEM): the responder end of the GMEM port that the memory management unit drives as initiator. Accepts single-outstanding write and read bursts on independent channel FSMs, stores beats in a synchronous dual-port RAM, and returns B and R responses. Used as the GMEM target in simulation and as an on-chip scratch memory in FPGA builds.

## Interface
- ID_WIDTH, 4, AXI ID width
- GMEM_ADDR_W, 28, byte address width
- GMEM_DATA_W, 128, beat width; byte offset bits OFS = log2(GMEM_DATA_W/8) = 4
- MEM_DEPTH_W, 10, log2 of RAM depth in beats
- clk  in  1  clock
- clear  in  1  synchronous active-high reset
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/GMEM_ADDR_W/8/3/2  write address; lock/cache/prot/qos accepted and ignored
- s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata/wstrb/wlast/wvalid  in  GMEM_DATA_W/GMEM_DATA_W/8/1/1; s_axi_wready out 1
- s_axi_bid out ID_WIDTH; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1
- s_axi_arid/araddr/arlen/arsize/arburst  in  as AW; s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rid out ID_WIDTH; s_axi_rdata out GMEM_DATA_W; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1

## Operation
- Beat index = addr[OFS+MEM_DEPTH_W-1:OFS]; addr[OFS-1:0] ignored; upper bits alias. Index increments per beat mod 2^MEM_DEPTH_W (wraps 1023->0). burst 2'b00 FIXED holds index; 2'b01 and 2'b10 treated as INCR.
- Write FSM: W_IDLE (awready=1) -> on awvalid&awready latch id, index, len, size -> W_DATA (wready=1); each wvalid&wready writes one beat and increments beat count; on beat count == awlen -> W_RESP (bvalid=1, bid=latched id) -> on bready -> W_IDLE.
- bresp = 2'b10 SLVERR if awsize != OFS (RAM writes suppressed for whole burst) or if wlast mismatches (asserted before final beat, or deasserted on final beat; data still written). Otherwise 2'b00 OKAY. Burst always ends after awlen+1 beats.
- Read FSM: R_IDLE (arready=1) -> on handshake latch id, index, len, size -> R_FETCH (issue RAM read) -> R_DATA. One-beat output register plus one skid entry; next RAM read issued only when a slot is free, so rready backpressure never drops or duplicates beats. rlast=1 on beat arlen. After last beat accepted -> R_IDLE.
- Bad arsize: returns arlen+1 beats with rdata=0, rresp=2'b10.
- RAM port collision (read and write same index, same cycle): read returns old data.
- clear: both FSMs -> idle, counters zeroed, all valid/ready outputs 0, bid/rid/bresp/rresp/rlast/rdata 0; RAM contents preserved. Burst in flight when clear asserted is abandoned (no B/R response).

## Timing
- All outputs registered or decoded from registered state; no input-to-output combinational path except none.
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0; in the first cycle after clear deasserts awready=arready=1.
- Write: AW handshake at T -> wready=1 at T+1; last W handshake at U -> bvalid=1 at U+1.
- Read: AR handshake at T -> first rvalid at T+2; with rready held 1, one beat per cycle thereafter (burst of N+1 beats completes at T+2+N).
- Back-to-back: next awready at cycle after B handshake; next arready at cycle after last R handshake.
- Write and read channels fully concurrent.

## Configuration
- GMEM_STRB_EN defined: wstrb honored per byte; bytes with strobe 0 unchanged.
- Not defined: wstrb ignored, every accepted beat writes all GMEM_DATA_W bits.

## Test plan
- Write awaddr=0x100, awlen=3, awsize=4, data 0xA..0xD, wlast on beat 3 -> bresp=00 one cycle after last beat; read same burst -> rdata 0xA..0xD, rlast on 4th beat, first rvalid 2 cycles after AR.
- Read burst awlen=7 with rready toggling 1,0,0,1 pattern -> all 8 beats delivered in order, no duplicates, rlast only on beat 7.
- Write index 1022, awlen=3 -> beats land at 1022,1023,0,1 (verified by read-back); awsize=3 write -> bresp=10, memory unchanged.
- wlast asserted on beat 1 of awlen=3 -> 4 beats accepted, bresp=10; with GMEM_STRB_EN wstrb=0x000F over 0xFF..FF pattern -> only low 4 bytes change; without macro all 16 bytes change.
- Assert clear mid read burst (beat 2 of 8) -> rvalid=0 next cycle, arready=1 the cycle after clear drops, previously written data still readable.
